// File: rtl/muldiv_unit_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
// master = execute stage / D/X registers, slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       aluop;
  logic [WIDTH-1:0] rA;
  logic [WIDTH-1:0] rB;
  logic             signed_op;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output aluop, rA, rB, signed_op,
    input  hi, lo, mf_data, busy, done, stall
  );

  modport slave (
    input  aluop, rA, rB, signed_op,
    output hi, lo, mf_data, busy, done, stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV unit owning HI/LO: one bit per cycle on magnitudes,
// followed by a single sign-fix cycle that commits HI/LO.
module muldiv_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [5:0] MULT_OP = 6'b000010,
  parameter logic [5:0] DIV_OP  = 6'b000011,
  parameter logic [5:0] MFHI_OP = 6'b000100,
  parameter logic [5:0] MFLO_OP = 6'b000101
) (
  input logic         clock,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic [5:0]         r_count;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_orig_a;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_busy;
  logic               r_done;

  logic               w_start_mul;
  logic               w_start_div;
  logic               w_is_mf;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_start_mul = (bus.aluop == MULT_OP);
  assign w_start_div = (bus.aluop == DIV_OP);
  assign w_is_mf     = (bus.aluop == MFHI_OP) || (bus.aluop == MFLO_OP);

  assign w_neg_a = bus.signed_op & bus.rA[WIDTH-1];
  assign w_neg_b = bus.signed_op & bus.rB[WIDTH-1];
  assign w_mag_a = w_neg_a ? -bus.rA : bus.rA;
  assign w_mag_b = w_neg_b ? -bus.rB : bus.rB;

  // Multiply: r_prod = {partial sum, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                     (r_prod[0] ? {1'b0, r_opnd} : '0);

  // Divide: r_prod = {remainder, dividend bits shifting out / quotient bits shifting in}.
  // The remainder stays below the divisor, so a 33-bit difference's top bit is the borrow.
  assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok    = ~w_div_diff[WIDTH];

  assign w_last     = (r_count == 6'(WIDTH-1));
  assign w_prod_fix = r_neg_res ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg_res ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_opnd    <= '0;
      r_orig_a  <= '0;
      r_prod    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_mul || w_start_div) begin
            r_opnd    <= w_start_mul ? w_mag_a : w_mag_b;
            r_prod    <= {{WIDTH{1'b0}}, (w_start_mul ? w_mag_b : w_mag_a)};
            r_orig_a  <= bus.rA;
            r_is_div  <= w_start_div;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= w_start_mul ? S_MUL : S_DIV;
          end
        end
        S_MUL: begin
          r_prod  <= {w_mul_sum, r_prod[WIDTH-1:1]};
          r_count <= r_count + 6'd1;
          if (w_last) r_state <= S_FIX;
        end
        S_DIV: begin
          r_prod  <= {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                      r_prod[WIDTH-2:0], w_div_ok};
          r_count <= r_count + 6'd1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else if (r_opnd == '0) begin
            // Divide by zero reports the dividend exactly as it was issued.
            r_hi <= r_orig_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.stall   = r_busy & (w_start_mul | w_start_div | w_is_mf);
  assign bus.mf_data = (bus.aluop == MFHI_OP) ? r_hi :
                       (bus.aluop == MFLO_OP) ? r_lo : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference
// model of HI/LO, busy window, done pulse, interlock and MF read data.
module tb_muldiv_unit;
  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;
  localparam logic [5:0] ADD_OP  = 6'b100000;
  localparam logic [5:0] NOP_OP  = 6'b000000;
  localparam int LATENCY = 33;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {hi, lo} from plain arithmetic on the issued operands.
  function automatic logic [63:0] ref_result(input bit is_div, input bit s,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      if (s) t = 64'(sa * sb);
      else   t = {32'b0, a} * {32'b0, b};
      return t;
    end
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (s) begin
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Reference model: architectural HI/LO plus cycles left in the current operation.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  bit          m_done = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
        end
      end else if (bus.aluop == MULT_OP || bus.aluop == DIV_OP) begin
        {p_hi, p_lo} <= ref_result(bus.aluop == DIV_OP, bus.signed_op, bus.rA, bus.rB);
        m_left <= LATENCY;
      end
    end
  end

  always @(negedge clock) begin
    logic e_busy, e_stall;
    logic [31:0] e_mf;
    e_busy  = (m_left > 0);
    e_stall = e_busy && (bus.aluop inside {MULT_OP, DIV_OP, MFHI_OP, MFLO_OP});
    e_mf    = (bus.aluop == MFHI_OP) ? m_hi : (bus.aluop == MFLO_OP) ? m_lo : 32'd0;
    check32("busy",    32'(bus.busy),  32'(e_busy));
    check32("done",    32'(bus.done),  32'(m_done));
    check32("stall",   32'(bus.stall), 32'(e_stall));
    check32("hi",      bus.hi, m_hi);
    check32("lo",      bus.lo, m_lo);
    check32("mf_data", bus.mf_data, e_mf);
  end

  // Present one instruction in D/X and hold it while stalled.
  task automatic drive(input logic [5:0] op, input bit s, input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.aluop = op; bus.signed_op = s; bus.rA = a; bus.rB = b;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      if (!bus.stall) break;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL drive_timeout: stall still %b after %0d cycles, want 0", bus.stall, n);
    end
    @(posedge clock); #2;
  endtask

  task automatic run_op(input string name, input logic [5:0] op, input bit s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] x_hi, input logic [31:0] x_lo);
    int busy_cyc, dones, n;
    drive(op, s, a, b);
    bus.aluop = NOP_OP;
    busy_cyc = 0; dones = 0; n = 0;
    while (n < 100) begin
      @(negedge clock);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin dones++; break; end
      n++;
    end
    check32({name, "_busy_cycles"}, busy_cyc, LATENCY);
    check32({name, "_done_pulses"}, dones, 1);
    check32({name, "_hi"}, bus.hi, x_hi);
    check32({name, "_lo"}, bus.lo, x_lo);
    @(posedge clock); #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clock);
      if (!bus.busy) break;
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", bus.busy, n);
    end
    @(posedge clock); #2;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'(($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    int n;
    bus.aluop = NOP_OP; bus.signed_op = 1'b0; bus.rA = '0; bus.rB = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check32("reset_hi", bus.hi, 32'h0);
    check32("reset_busy", 32'(bus.busy), 32'h0);

    r = ref_result(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5);
    check32("model_smul", r[31:0], 32'hFFFFFFF1);
    r = ref_result(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
    check32("model_sdiv_hi", r[63:32], 32'hFFFFFFFF);
    r = ref_result(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    check32("model_ovf_lo", r[31:0], 32'h80000000);

    @(posedge clock); #2;
    run_op("umul",   MULT_OP, 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A);
    run_op("smul",   MULT_OP, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("umulmx", MULT_OP, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);
    run_op("sdiv",   DIV_OP,  1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("udiv",   DIV_OP,  1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div0",   DIV_OP,  1'b0, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
    run_op("sdiv0",  DIV_OP,  1'b1, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF);
    run_op("ovf",    DIV_OP,  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // Interlock: MFLO right behind a MULT stalls until HI/LO are committed.
    drive(MULT_OP, 1'b0, 32'd3, 32'd4);
    bus.aluop = MFLO_OP;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      if (!bus.stall) break;
      n++;
    end
    check32("mflo_stall_cycles", n, LATENCY);
    check32("mflo_first_data", bus.mf_data, 32'd12);
    @(posedge clock); #2;

    // Unrelated instruction while busy is not stalled.
    drive(MULT_OP, 1'b0, 32'd5, 32'd6);
    bus.aluop = ADD_OP;
    @(negedge clock);
    check32("add_no_stall", 32'(bus.stall), 32'h0);
    check32("add_busy", 32'(bus.busy), 32'h1);
    wait_idle();

    // Reset partway through a divide.
    drive(DIV_OP, 1'b0, 32'd1000, 32'd7);
    bus.aluop = NOP_OP;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check32("rst_mid_busy", 32'(bus.busy), 32'h0);
    check32("rst_mid_hi", bus.hi, 32'h0);
    check32("rst_mid_lo", bus.lo, 32'h0);
    @(posedge clock); #2 reset = 1'b0;
    repeat (40) @(posedge clock);
    #2;
    run_op("mul_after_rst", MULT_OP, 1'b0, 32'd2, 32'd3, 32'h0, 32'd6);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 6))
        0, 1: op = MULT_OP;
        2, 3: op = DIV_OP;
        4:    op = MFHI_OP;
        5:    op = MFLO_OP;
        default: op = ADD_OP;
      endcase
      drive(op, 1'($urandom_range(0, 1)), pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) begin
        bus.aluop = NOP_OP;
        repeat ($urandom_range(1, 40)) @(posedge clock);
        #2;
      end
    end
    bus.aluop = NOP_OP;
    wait_idle();
    repeat (3) @(posedge clock);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit beside the execute stage of the 5-stage MIPS pipeline.
- Consumes operands and aluop from the D/X registers, and owns the architectural HI/LO registers.
- Supplies MFHI/MFLO read data to execute and raises a pipeline stall while a MULT/DIV is in flight.
- Computes one bit per cycle (shift-add multiply, restoring divide) with a final sign-fix cycle.

Parameters:
MULT_OP, 6'b000010, aluop encoding that starts a multiply
DIV_OP, 6'b000011, aluop encoding that starts a divide
MFHI_OP, 6'b000100, aluop encoding that reads HI
MFLO_OP, 6'b000101, aluop encoding that reads LO
WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
clock  input  1  pipeline clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
aluop  input  6  aluop from D/X register
rA  input  32  operand A (dividend / multiplicand), already bypassed
rB  input  32  operand B (divisor / multiplier), already bypassed
signed_op  input  1  1 = signed MULT/DIV, 0 = MULTU/DIVU
hi  output  32  architectural HI register
lo  output  32  architectural LO register
mf_data  output  32  combinational: hi when aluop==MFHI_OP, lo when aluop==MFLO_OP, else 0
busy  output  1  registered: operation in flight
done  output  1  registered: one-cycle pulse when HI/LO updated
stall  output  1  combinational interlock to fetch and the D/X hold logic

Behaviour:
- Reset (async, immediate): state=IDLE; hi=0, lo=0, busy=0, done=0, count=0, all datapath registers 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - On a clock edge with aluop==MULT_OP, latch |rA|, |rB| (magnitudes when signed_op; raw when unsigned) and result sign; then busy<=1, count<=0, go to MUL.
  - aluop==DIV_OP does the same but goes to DIV, also latching the dividend sign.
  - Any other aluop: stay in IDLE.
- MUL: each edge performs one shift-add step on a 64-bit product register and increments count. On the edge that completes step WIDTH-1, go to FIX.
- DIV: each edge performs one restoring step (shift remainder left, trial-subtract divisor, set quotient bit when non-negative) and increments count. After WIDTH steps, go to FIX.
- FIX: on one edge, apply sign correction, write hi/lo, pulse done=1, set busy<=0, go to IDLE. done falls on the next edge.
- Latency: start sampled at edge E; steps at edges E+1..E+WIDTH; FIX at edge E+WIDTH+1. New hi/lo are visible after edge E+33; busy is high for exactly 33 cycles.
- Multiply results:
  - Signed: the 64-bit two's-complement product; hi = [63:32], lo = [31:0].
  - Unsigned: the raw 64-bit product.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (signed).
  - Unsigned: plain quotient and remainder.
  - Divisor zero: lo=32'hFFFFFFFF, hi=rA as latched (original, un-negated). The full 33-cycle latency still applies.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0 (wrap, no trap).
- stall = busy & (aluop is MULT_OP, DIV_OP, MFHI_OP or MFLO_OP). Other instructions proceed while busy.
- A MULT/DIV aluop arriving while busy is ignored by the FSM. stall holds it in D/X until IDLE, and it is then accepted.
- While stall is high the pipeline holds D/X, so aluop is stable. Sampling a held MULT/DIV in IDLE starts exactly one operation.
- hi/lo change only in FIX or on reset. mf_data reflects the registered hi/lo, with no forwarding from an in-flight result.
- Reset mid-operation: returns to IDLE at once. hi/lo are cleared to 0 and no done pulse is issued.
- Counter is 6 bits; it never wraps in normal operation and is cleared on IDLE→MUL/DIV.

Test Plan:
- Unsigned multiply: MULT, signed_op=0, rA=7, rB=6 → busy high 33 cycles, done pulse at E+33, hi=0, lo=0x0000002A.
- Sign handling: MULT signed, rA=0xFFFFFFFD(-3), rB=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT unsigned, rA=rB=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide: DIV signed, rA=0xFFFFFFF9(-7), rB=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV unsigned, rA=100, rB=7 → lo=14, hi=2.
- Divide corners: DIV rB=0, rA=0x1234 → lo=0xFFFFFFFF, hi=0x1234 after 33 cycles. DIV signed 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Interlock: MULT 3×4, then MFLO presented the next cycle → stall=1 until FIX. mf_data=12 on the first cycle stall=0. An ADD presented during busy sees stall=0.
- Reset mid-operation: assert reset at step 10 of a DIV → busy=0, hi=lo=0 asynchronously, no done pulse. A subsequent MULT 2×3 completes with lo=6.
